// File: rtl/apb3_arbiter_master.sv
// Two-requester round-robin APB3 master with a two-slave address decode and wait-state timeout.
// state  | meaning
// IDLE   | arbitrate, latch winner's command, decode address
// SETUP  | psel high, penable low
// ACCESS | penable high, wait for pready or timeout
// DONE   | one-cycle completion pulse to the owner
module apb3_arbiter_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              write_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              done_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              err_a,
    input  logic              req_b,
    input  logic              write_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              err_b,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel1,
    output logic              psel2,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q;
    logic              owner_b_q;
    logic              prio_b_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              done_a_q, done_b_q, err_a_q, err_b_q;
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q, pwdata_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q, psel1_q, psel2_q, penable_q;

    logic              grant_b;
    logic              grant_write;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              in_map;
    logic              fin, fin_b, fin_err;
    logic [DATA_W-1:0] fin_rdata;

    always_comb begin
        grant_b     = req_b && (!req_a || prio_b_q);
        grant_write = grant_b ? write_b : write_a;
        grant_addr  = grant_b ? addr_b  : addr_a;
        grant_wdata = grant_b ? wdata_b : wdata_a;
        in_map      = (grant_addr[ADDR_W-1:9] == '0);
    end

    // Completion of the current transfer on this edge, shared by the decode-error and bus paths.
    always_comb begin
        fin       = 1'b0;
        fin_b     = owner_b_q;
        fin_err   = 1'b0;
        fin_rdata = '0;
        case (state_q)
            IDLE: begin
                if ((req_a || req_b) && !in_map) begin
                    fin     = 1'b1;
                    fin_b   = grant_b;
                    fin_err = 1'b1;
                end
            end
            ACCESS: begin
                if (pready) begin
                    fin       = 1'b1;
                    fin_err   = pslverr;
                    fin_rdata = pwrite_q ? '0 : prdata;
                end else if (wait_cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_b_q  <= 1'b0;
            prio_b_q   <= 1'b0;
            wait_cnt_q <= '0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            psel1_q    <= 1'b0;
            psel2_q    <= 1'b0;
            penable_q  <= 1'b0;
        end else begin
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner_b_q  <= grant_b;
                        prio_b_q   <= !grant_b;
                        paddr_q    <= grant_addr;
                        pwrite_q   <= grant_write;
                        pwdata_q   <= grant_wdata;
                        wait_cnt_q <= CNT_LOAD;
                        if (in_map) begin
                            psel1_q <= !grant_addr[8];
                            psel2_q <= grant_addr[8];
                            state_q <= SETUP;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (fin) begin
                        psel1_q   <= 1'b0;
                        psel2_q   <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (fin) begin
                if (fin_b) begin
                    done_b_q  <= 1'b1;
                    rdata_b_q <= fin_rdata;
                    err_b_q   <= fin_err;
                end else begin
                    done_a_q  <= 1'b1;
                    rdata_a_q <= fin_rdata;
                    err_a_q   <= fin_err;
                end
            end
        end
    end

    assign done_a  = done_a_q;
    assign rdata_a = rdata_a_q;
    assign err_a   = err_a_q;
    assign done_b  = done_b_q;
    assign rdata_b = rdata_b_q;
    assign err_b   = err_b_q;
    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;
    assign psel1   = psel1_q;
    assign psel2   = psel2_q;
    assign penable = penable_q;
endmodule
